// File: rtl/laneswitch_arbiter_pkg.sv
// Shared types for the lane-switch arbiter: FSM state encoding, lane ids and lane mask helper.
package laneswitch_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SWAP   = 3'd3,
    ST_SETTLE = 3'd4
  } state_e;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  function automatic logic [1:0] lane_mask(input logic lane);
    return (lane == LANE1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lsa_cycle_counter.sv
// Clear/enable cycle counter; `last` flags the TERMINAL-th consecutive enabled cycle.
// Combinational compare on the registered count, no handshake or backpressure.
module lsa_cycle_counter
  import laneswitch_arbiter_pkg::*;
#(
  parameter int TERMINAL = 2,
  parameter int WIDTH    = $clog2(TERMINAL + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [WIDTH-1:0] TC_M1 = WIDTH'(TERMINAL - 1);

  logic [WIDTH-1:0] cnt;

  assign last = en && !clr && (cnt == TC_M1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/laneswitch_arbiter.sv
// Grants the shared buffer to one lane, drains, flips the lane mux and lets it settle before re-grant.
// Registered outputs; re-grant 1 cycle for the owner, 2+SETTLE_CYCLES after a swap; lanes wait on grant.
module laneswitch_arbiter
  import laneswitch_arbiter_pkg::*;
#(
  parameter logic INIT_OWNER    = LANE0,
  parameter int   DRAIN_CYCLES  = 2,
  parameter int   SETTLE_CYCLES = 1,
  parameter int   DRAIN_TIMEOUT = 256,
  parameter int   CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           req,
  input  logic [1:0]           rel,
  output logic [1:0]           grant,
  output logic                 switch,
  input  logic                 mem_active,
  input  logic                 mem_fault,
  output logic                 busy,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] swap_count
);

  state_e     state;
  logic       other;
  logic [1:0] own_mask;
  logic       in_drain;
  logic       in_settle;
  logic       rel_ok;
  logic       rel_bad;
  logic       quiet_done;
  logic       drain_expired;
  logic       drain_abort;
  logic       settle_done;
  logic       err_evt;

  // The owner is whatever lane the mux currently points at.
  assign other     = ~switch;
  assign own_mask  = lane_mask(switch);
  assign in_drain  = (state == ST_DRAIN);
  assign in_settle = (state == ST_SETTLE);

  // Only a lone release from the granted owner ends ownership; anything else is a protocol error.
  assign rel_ok  = (state == ST_GRANT) && (rel == own_mask);
  assign rel_bad = (rel != 2'b00) && !rel_ok;

  assign drain_abort = drain_expired && !quiet_done;

  assign err_evt = mem_fault
                || (mem_active && ((state == ST_SWAP) || in_settle))
                || rel_bad
                || drain_abort;

  lsa_cycle_counter #(.TERMINAL(DRAIN_CYCLES)) u_quiet (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!in_drain || mem_active),
    .en      (in_drain),
    .last    (quiet_done)
  );

  // Fires on the first DRAIN cycle beyond the allowed budget.
  lsa_cycle_counter #(.TERMINAL(DRAIN_TIMEOUT + 1)) u_drain_to (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!in_drain),
    .en      (in_drain),
    .last    (drain_expired)
  );

  lsa_cycle_counter #(.TERMINAL(SETTLE_CYCLES)) u_settle (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!in_settle),
    .en      (in_settle),
    .last    (settle_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      switch     <= INIT_OWNER;
      busy       <= 1'b0;
      swap_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Non-owner wins a tie so the two lanes alternate.
          if (req[other]) begin
            state <= ST_SWAP;
            busy  <= 1'b1;
          end else if (req[switch]) begin
            state <= ST_GRANT;
            grant <= own_mask;
            busy  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (rel_ok) begin
            state <= ST_DRAIN;
            grant <= 2'b00;
          end
        end
        ST_DRAIN: begin
          if (quiet_done) begin
            if (req[other]) begin
              state <= ST_SWAP;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (drain_abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_SWAP: begin
          state      <= ST_SETTLE;
          switch     <= other;
          swap_count <= swap_count + CNT_WIDTH'(1);
        end
        ST_SETTLE: begin
          if (settle_done) begin
            if (req[switch]) begin
              state <= ST_GRANT;
              grant <= own_mask;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error <= 1'b0;
    end else if (err_evt) begin
      error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_laneswitch_arbiter.sv
// Scoreboard bench: driver predicts grant edges from handover timing rules, monitor checks every cycle.
module tb_laneswitch_arbiter;

  localparam int DRAIN   = 2;
  localparam int SETTLE  = 1;
  localparam int TIMEOUT = 256;
  localparam int CW      = 16;
  localparam int NEVER   = 32'h7fffffff;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req;
  logic [1:0]    rel;
  logic [1:0]    grant;
  logic          switch;
  logic          mem_active;
  logic          mem_fault;
  logic          busy;
  logic          error;
  logic [CW-1:0] swap_count;

  laneswitch_arbiter #(
    .INIT_OWNER    (1'b0),
    .DRAIN_CYCLES  (DRAIN),
    .SETTLE_CYCLES (SETTLE),
    .DRAIN_TIMEOUT (TIMEOUT),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .rel        (rel),
    .grant      (grant),
    .switch     (switch),
    .mem_active (mem_active),
    .mem_fault  (mem_fault),
    .busy       (busy),
    .error      (error),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] g;
    logic       sw;
    int         sc;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   err_cyc  = NEVER;
  logic owner    = 1'b0;
  int   swaps    = 0;

  function automatic logic [1:0] lm(input logic l);
    return l ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int c, input logic [1:0] g, input logic sw, input int sc);
    ev_t e;
    e.cyc = c; e.g = g; e.sw = sw; e.sc = sc;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  initial begin
    logic [1:0] prev_g;
    logic       prev_sw;
    ev_t        e;
    prev_g  = 2'b00;
    prev_sw = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n === 1'b1) begin
        check("grant_onehot0", 32'($onehot0(grant)), 1);
        check("error_level", error, (cyc >= err_cyc));
        if (grant != 2'b00 && prev_g != 2'b00) check("switch_stable_under_grant", switch, prev_sw);
        if (grant !== prev_g) begin
          if (exp_q.size() == 0) begin
            check("unexpected_grant_change", grant, prev_g);
          end else begin
            e = exp_q.pop_front();
            check("grant_cycle", cyc, e.cyc);
            check("grant_value", grant, e.g);
            check("switch_at_grant_edge", switch, e.sw);
            check("swap_count_at_grant_edge", swap_count, e.sc);
          end
        end
      end
      prev_g  = grant;
      prev_sw = switch;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, expected to have finished");
    $fatal(1, "watchdog expired");
  end

  // Called on a falling edge; checks the outputs drop asynchronously.
  task automatic do_reset();
    check("queue_drained_before_reset", exp_q.size(), 0);
    reset_n = 1'b0;
    req = 2'b00; rel = 2'b00; mem_active = 1'b0; mem_fault = 1'b0;
    owner = 1'b0; swaps = 0; err_cyc = NEVER;
    #1;
    check("reset_grant", grant, 0);
    check("reset_switch", switch, 0);
    check("reset_busy", busy, 0);
    check("reset_error", error, 0);
    check("reset_swap_count", swap_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_random(input int n);
    int   lane, k, r, rise, done, hold, a;
    bit   granted, other_pend, want, both;
    logic winner;
    granted    = 0;
    other_pend = 0;
    lane       = 0;
    for (int t = 0; t < n; t++) begin
      if (!granted) begin
        if (t > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        lane = (t == 0) ? 0 : int'($urandom_range(0, 1));
        both = (t >= 2) && ($urandom_range(0, 3) == 0);
        k = cyc;
        if (both) begin
          req = 2'b11; winner = ~owner; other_pend = 1;
        end else begin
          req = lm(lane[0]); winner = lane[0]; other_pend = 0;
        end
        if (winner == owner) begin
          rise = k + 1;
        end else begin
          rise = k + 2 + SETTLE;
          owner = winner;
          swaps++;
        end
        lane = int'(winner);
        push(rise, lm(winner), winner, swaps);
        wait_cyc(rise);
        granted = 1;
      end
      hold = $urandom_range(0, 4);
      want = (t < 2) ? 1'b1 : (other_pend || ($urandom_range(0, 1) == 1));
      for (int h = 0; h < hold; h++) begin
        mem_active = $urandom_range(0, 1);
        if ($urandom_range(0, 3) == 0) req[lane] = 1'b0;
        if (want && $urandom_range(0, 1) == 1) req[~lane[0]] = 1'b1;
        @(negedge clk);
      end
      r = cyc;
      rel = lm(lane[0]);
      req[lane] = 1'b0;
      if (want) req[~lane[0]] = 1'b1;
      mem_active = $urandom_range(0, 1);
      push(r + 1, 2'b00, owner, swaps);
      @(negedge clk);
      rel = 2'b00;
      a = (t == 0) ? 0 : (t == 1) ? 3 : int'($urandom_range(0, 3));
      for (int i = 0; i < a; i++) begin
        mem_active = 1'b1;
        @(negedge clk);
      end
      mem_active = 1'b0;
      done = r + 1 + a + DRAIN;
      if (want) begin
        owner = ~owner;
        swaps++;
        lane = int'(owner);
        rise = done + 1 + SETTLE;
        push(rise, lm(owner), owner, swaps);
        wait_cyc(rise);
        granted    = 1;
        other_pend = 0;
      end else begin
        wait_cyc(done);
        granted = 0;
      end
    end
  endtask

  initial begin
    int k, r;
    reset_n = 1'b0;
    req = 2'b00; rel = 2'b00; mem_active = 1'b0; mem_fault = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    run_random(40);
    @(negedge clk);
    do_reset();

    // mem_active stuck high through DRAIN: timeout abort, no swap
    k = cyc; req = 2'b01;
    push(k + 1, 2'b01, 1'b0, 0);
    wait_cyc(k + 1);
    r = cyc; rel = 2'b01; req = 2'b00;
    push(r + 1, 2'b00, 1'b0, 0);
    @(negedge clk);
    rel = 2'b00; mem_active = 1'b1;
    err_cyc = r + 2 + TIMEOUT;
    wait_cyc(r + 1 + TIMEOUT);
    check("drain_busy_before_timeout", busy, 1);
    wait_cyc(r + 2 + TIMEOUT);
    check("timeout_idle", busy, 0);
    check("timeout_switch_kept", switch, 0);
    check("timeout_no_swap", swap_count, 0);
    check("timeout_error", error, 1);
    mem_active = 1'b0;
    @(negedge clk);
    do_reset();

    // release from the non-owner while lane0 holds the grant
    k = cyc; req = 2'b01;
    push(k + 1, 2'b01, 1'b0, 0);
    wait_cyc(k + 1);
    rel = 2'b10; err_cyc = k + 2;
    @(negedge clk);
    rel = 2'b00;
    check("bad_release_grant_kept", grant, 2'b01);
    check("bad_release_error", error, 1);
    check("bad_release_busy", busy, 1);
    do_reset();

    // mem_fault pulse while lane0 holds the grant
    k = cyc; req = 2'b01;
    push(k + 1, 2'b01, 1'b0, 0);
    wait_cyc(k + 1);
    mem_fault = 1'b1; err_cyc = k + 2;
    @(negedge clk);
    mem_fault = 1'b0;
    check("fault_grant_kept", grant, 2'b01);
    check("fault_error", error, 1);
    do_reset();

    // memory still active during SWAP: error flagged, handover still completes
    k = cyc; req = 2'b10;
    push(k + 2 + SETTLE, 2'b10, 1'b1, 1);
    wait_cyc(k + 1);
    check("swap_switch_not_yet", switch, 0);
    mem_active = 1'b1; err_cyc = k + 2;
    @(negedge clk);
    mem_active = 1'b0;
    wait_cyc(k + 2 + SETTLE);
    check("active_in_swap_error", error, 1);
    do_reset();

    // reset asserted while in SETTLE
    k = cyc; req = 2'b10;
    wait_cyc(k + 1);
    check("settle_pre_switch", switch, 0);
    check("settle_pre_busy", busy, 1);
    wait_cyc(k + 2);
    check("settle_switch", switch, 1);
    check("settle_swap_count", swap_count, 1);
    check("settle_grant", grant, 0);
    do_reset();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
